alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Multi-cycle execution controller for the 8-bit datapath.
- Accepts one decoded instruction at a time from the instruction decoder through a valid/ready handshake.
- Drives the ALU source-select code, ALU function and accumulator write enable.
- Sequences data-memory reads and writes with an acknowledge handshake and a bounded timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles a DM strobe is held without DM_ACK before fault; legal range 0..255; 0 = wait forever

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
INSTR_VALID  in  1  decoder presents an instruction
INSTR_READY  out  1  controller can accept an instruction
INSTR_OP  in  4  instruction class: 0 NOP, 1 ALU-RF, 2 ALU-ID (immediate), 3 ALU-DM, 4 STORE; 5..15 illegal
INSTR_FN  in  3  ALU function code, passed through to ALU_FN
SRC  out  2  ALU mux select: 00 RF, 01 ID, 11 DM; 10 never driven
ALU_FN  out  3  latched ALU function
ACC_WE  out  1  accumulator/RF write enable
DM_RE  out  1  data-memory read strobe
DM_WE  out  1  data-memory write strobe
DM_ACK  in  1  data-memory access complete
BUSY  out  1  controller is not in IDLE
DONE  out  1  one-cycle instruction-retired pulse
ILLEGAL  out  1  one-cycle pulse with DONE for an illegal opcode
ERR  out  1  one-cycle DM timeout pulse

Behaviour:
- Clocking and reset:
  - Single clock CLK. RST is synchronous, active-high.
  - RST forces state IDLE and clears OP/FN latches and the timeout counter.
- Output decoding:
  - All outputs are decoded from registered state plus latched OP/FN (Moore).
  - Reset values: INSTR_READY=1; SRC=00, ALU_FN=000, ACC_WE=0, DM_RE=0, DM_WE=0, BUSY=0, DONE=0, ILLEGAL=0, ERR=0.
- States: IDLE, DECODE, MEM_RD, EXEC, WB, MEM_WR, FINISH, FAULT.
- IDLE:
  - INSTR_READY=1; no other output active.
  - On INSTR_VALID=1, latch INSTR_OP/INSTR_FN and go to DECODE.
  - INSTR_READY=0 in every other state; the decoder holds VALID.
- DECODE (1 cycle):
  - OP 1 or 2 -> EXEC; OP 3 -> MEM_RD; OP 4 -> MEM_WR.
  - OP 0 -> FINISH; illegal OP -> FINISH with the illegal flag set.
- MEM_RD:
  - DM_RE=1 every cycle in this state.
  - DM_ACK=1 -> EXEC.
  - Otherwise the counter increments; if it reaches MEM_TIMEOUT-1 with no ACK -> FAULT.
  - Result: the strobe is held exactly MEM_TIMEOUT cycles before fault.
- MEM_WR:
  - DM_WE=1 every cycle in this state.
  - DM_ACK=1 -> FINISH.
  - Same timeout rule as MEM_RD -> FAULT.
- Timeout counter:
  - 8-bit, cleared on every entry to MEM_RD/MEM_WR.
  - DM_ACK in the same cycle as the terminal count: ACK wins, no fault.
- EXEC (1 cycle):
  - SRC=00 for OP 1, 01 for OP 2, 11 for OP 3; ALU_FN=latched FN. Then -> WB.
- WB (1 cycle):
  - SRC and ALU_FN held from EXEC; ACC_WE=1. Then -> FINISH.
- FINISH (1 cycle):
  - DONE=1; ILLEGAL=1 if the latched OP was illegal. Then -> IDLE.
- FAULT (1 cycle):
  - ERR=1, DONE=0. Then -> IDLE. The accumulator is not written.
- SRC outside EXEC/WB = 00. BUSY = (state != IDLE).
- Latency, counted from the handshake edge:
  - ALU-RF/ALU-ID: DONE 4 cycles after handshake; next accept on cycle 5.
  - NOP: DONE after 2 cycles.
  - ALU-DM: 4 + (DM wait cycles, min 1).
  - STORE: 2 + wait cycles, min 1.
- Reset mid-operation:
  - Next edge returns to IDLE; DM strobes drop immediately after that edge.
  - No DONE/ERR for the aborted instruction.
- MEM_TIMEOUT=0: the counter never faults.
- Stray DM_ACK outside MEM states is ignored.

Optional Feature:
- Macro: ALU_EXEC_CTRL_PERF_EN.
- Defined: adds output port INSTR_CNT [15:0].
  - Increments on every DONE pulse (illegal included); ERR pulses are not counted.
  - Saturates at 16'hFFFF; cleared by RST.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with RST=1 for 2 cycles, then release -> INSTR_READY=1, SRC=00, all strobes 0, BUSY=0.
- OP=2, FN=3'b101, VALID for 1 handshake -> SRC=01 and ALU_FN=101 in EXEC/WB; ACC_WE=1 exactly in cycle 3; DONE in cycle 4; READY back in cycle 5.
- OP=3 with DM_ACK after 3 cycles of DM_RE -> DM_RE high 3 cycles; then SRC=11 in EXEC; ACC_WE once; DONE once; no ERR.
- OP=4, DM_ACK never asserted, MEM_TIMEOUT=15 -> DM_WE high exactly 15 cycles; ERR pulse 1 cycle; no DONE; READY=1 afterward.
- OP=4 with DM_ACK on the 15th strobe cycle -> no ERR; DONE pulse. Then OP=9 -> DONE and ILLEGAL together; ACC_WE never set.
- RST asserted during MEM_RD -> DM_RE=0 after that edge; no DONE/ERR. With ALU_EXEC_CTRL_PERF_EN: after 3 retired instructions, INSTR_CNT=3; after RST, INSTR_CNT=0.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execution controller: instruction handshake, ALU control and
// timed data-memory access. Optional macro ALU_EXEC_CTRL_PERF_EN adds instr_cnt_o.
module alu_exec_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [3:0] instr_op_i,
  input  logic [2:0] instr_fn_i,
  output logic [1:0] src_o,
  output logic [2:0] alu_fn_o,
  output logic       acc_we_o,
  output logic       dm_re_o,
  output logic       dm_we_o,
  input  logic       dm_ack_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       illegal_o,
  output logic       err_o
`ifdef ALU_EXEC_CTRL_PERF_EN
  ,
  output logic [15:0] instr_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MEM_RD, S_EXEC, S_WB, S_MEM_WR, S_FINISH, S_FAULT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_RF  = 4'd1;
  localparam logic [3:0] OP_ID  = 4'd2;
  localparam logic [3:0] OP_DM  = 4'd3;
  localparam logic [3:0] OP_ST  = 4'd4;

  // Last count value a strobe may be held at before the access is abandoned.
  localparam logic [7:0] TMO_TERM = (MEM_TIMEOUT == 0) ? 8'd0 : 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [2:0] fn_q, fn_d;
  logic [7:0] tmo_q, tmo_d;
  logic       tmo_hit;

  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_TERM);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the reset is synchronous here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      tmo_q   <= tmo_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    tmo_d   = '0;  // cleared outside memory states, so each entry starts at 0
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          state_d = S_DECODE;
          op_d    = instr_op_i;
          fn_d    = instr_fn_i;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_RF, OP_ID: state_d = S_EXEC;
          OP_DM:        state_d = S_MEM_RD;
          OP_ST:        state_d = S_MEM_WR;
          default:      state_d = S_FINISH;
        endcase
      end
      S_MEM_RD, S_MEM_WR: begin
        if (dm_ack_i) begin
          state_d = (state_q == S_MEM_RD) ? S_EXEC : S_FINISH;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready_o = 1'b0;
    src_o         = 2'b00;
    alu_fn_o      = 3'b000;
    acc_we_o      = 1'b0;
    dm_re_o       = 1'b0;
    dm_we_o       = 1'b0;
    done_o        = 1'b0;
    illegal_o     = 1'b0;
    err_o         = 1'b0;
    busy_o        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:   instr_ready_o = 1'b1;
      S_MEM_RD: dm_re_o = 1'b1;
      S_MEM_WR: dm_we_o = 1'b1;
      S_EXEC, S_WB: begin
        src_o    = (op_q == OP_RF) ? 2'b00 : (op_q == OP_ID) ? 2'b01 : 2'b11;
        alu_fn_o = fn_q;
        acc_we_o = (state_q == S_WB);
      end
      S_FINISH: begin
        done_o    = 1'b1;
        illegal_o = (op_q > OP_ST);
      end
      S_FAULT:  err_o = 1'b1;
      default:  ;
    endcase
  end

`ifdef ALU_EXEC_CTRL_PERF_EN
  logic [15:0] instr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_cnt_q <= '0;
    end else if (state_q == S_FINISH && instr_cnt_q != 16'hFFFF) begin
      instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
